// File: rtl/dispatch_rr_pkg.sv
// rtl/dispatch_rr_pkg.sv - shared types and onehot helpers for the round-robin dispatcher
// Helpers work on a fixed maximum width; callers zero-extend and truncate to PORT_NUM.
package dispatch_rr_pkg;

    localparam int MAX_PORTS = 32;
    localparam int IDX_W     = $clog2(MAX_PORTS);

    typedef logic [MAX_PORTS-1:0] onehot_t;

    // Rotate a onehot vector left by one within its low n bits (bit n-1 wraps to bit 0).
    function automatic onehot_t oh_rotl(input onehot_t v, input int n);
        onehot_t m;
        if (n >= MAX_PORTS) begin
            m = '1;
        end else begin
            m = (onehot_t'(1) << n) - onehot_t'(1);
        end
        return ((v << 1) | (v >> (n - 1))) & m;
    endfunction

    // Index of the lowest set bit; 0 for an all-zero vector.
    function automatic int oh_index(input onehot_t v);
        int idx;
        idx = 0;
        for (int i = MAX_PORTS - 1; i >= 0; i--) begin
            if (v[IDX_W'(i)]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/dispatch_rr_if.sv
// rtl/dispatch_rr_if.sv - upstream/downstream handshake bundle for the dispatcher
interface dispatch_rr_if #(
    parameter int PORT_NUM = 4,
    parameter int DATA_W   = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   in_data;
    logic [PORT_NUM-1:0] out_valid;
    logic [PORT_NUM-1:0] out_ready;
    logic [DATA_W-1:0]   out_data;
    logic                busy;

    modport master (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );

    modport slave (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/onehot_rr_pick.sv
// rtl/onehot_rr_pick.sv - cyclic first-set search over a mask, starting at a onehot base
// Purely combinational; returns zero when the mask is empty.
module onehot_rr_pick
    import dispatch_rr_pkg::*;
#(
    parameter int PORT_NUM = 4
) (
    input  logic [PORT_NUM-1:0] mask,
    input  logic [PORT_NUM-1:0] base,
    output logic [PORT_NUM-1:0] pick
);

    localparam int IW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

    int   start;
    int   j;
    logic found;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        start = oh_index(onehot_t'(base));
        j     = 0;
        for (int k = 0; k < PORT_NUM; k++) begin
            j = (start + k) % PORT_NUM;
            if (!found && mask[IW'(j)]) begin
                pick[IW'(j)] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dispatch_rr.sv
// rtl/dispatch_rr.sv - single-stage round-robin dispatcher: one upstream stream fanned to PORT_NUM ports
// A held item waits on its chosen port; the next search starts just past the last drained port.
module dispatch_rr
    import dispatch_rr_pkg::*;
#(
    parameter int PORT_NUM = 4,
    parameter int DATA_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PORT_NUM-1:0] base,
    input  logic [PORT_NUM-1:0] port_en,
    dispatch_rr_if.master       bus
);

    logic                full;
    logic [DATA_W-1:0]   data_q;
    logic [PORT_NUM-1:0] target_q;
    logic [PORT_NUM-1:0] base_q;
    logic [PORT_NUM-1:0] base_next;
    logic [PORT_NUM-1:0] pick;
    logic                drain;
    logic                load;

    assign drain = full & (|(target_q & bus.out_ready));

    // A same-cycle drain advances the base before the new item is placed.
    assign base_next = drain ? PORT_NUM'(oh_rotl(onehot_t'(target_q), PORT_NUM)) : base_q;

    assign bus.in_ready = (~full | drain) & (|port_en);
    assign load         = bus.in_valid & bus.in_ready;

    onehot_rr_pick #(
        .PORT_NUM (PORT_NUM)
    ) u_pick (
        .mask (port_en),
        .base (base_next),
        .pick (pick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full     <= 1'b0;
            data_q   <= '0;
            target_q <= '0;
            base_q   <= base;
        end else begin
            base_q <= base_next;
            if (load) begin
                full     <= 1'b1;
                data_q   <= bus.in_data;
                target_q <= pick;
            end else if (drain) begin
                full <= 1'b0;
            end
        end
    end

    assign bus.out_valid = full ? target_q : '0;
    assign bus.out_data  = data_q;
    assign bus.busy      = full;

endmodule

// File: tb/tb_dispatch_rr.sv
// tb/tb_dispatch_rr.sv - directed and random checks of dispatch_rr against a queue-level reference model
module tb_dispatch_rr;

    localparam int N = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] base;
    logic [N-1:0] port_en;

    dispatch_rr_if #(.PORT_NUM(N), .DATA_W(W)) bus ();

    dispatch_rr #(.PORT_NUM(N), .DATA_W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .base    (base),
        .port_en (port_en),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference model: at most one held item, its port index, and the index searching starts from.
    bit           m_full;
    int           m_tgt;
    int           m_base;
    logic [W-1:0] m_data;

    int total = 0;
    int bad   = 0;

    function automatic int first_from(input int b, input logic [N-1:0] en);
        for (int k = 0; k < N; k++) begin
            if (en[(b + k) % N]) return (b + k) % N;
        end
        return -1;
    endfunction

    function automatic int idx_of(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[k]) return k;
        end
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply inputs, check outputs against the model, then advance both one clock.
    task automatic cyc(input bit iv, input logic [W-1:0] id, input logic [N-1:0] ordy,
                       input logic [N-1:0] pe);
        logic [N-1:0] exp_ov;
        bit           exp_ir;
        bit           drn;
        int           t;
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.out_ready = ordy;
        port_en       = pe;
        #1;
        exp_ov = m_full ? N'(1 << m_tgt) : '0;
        exp_ir = (!m_full || ordy[m_tgt]) && (pe != 0);
        chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
        chk("busy", 32'(bus.busy), 32'(m_full));
        chk("in_ready", 32'(bus.in_ready), 32'(exp_ir));
        if (m_full) chk("out_data", 32'(bus.out_data), 32'(m_data));
        drn = m_full && ordy[m_tgt];
        if (drn) m_base = (m_tgt + 1) % N;
        if (iv && exp_ir) begin
            t      = first_from(m_base, pe);
            m_tgt  = t;
            m_data = id;
            m_full = 1'b1;
        end else if (drn) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [N-1:0] b);
        bus.in_valid = 1'b0;
        base         = b;
        rst_n        = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        m_full = 1'b0;
        m_base = idx_of(b);
        m_tgt  = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = '0;
        port_en       = 4'b1111;
        m_full        = 1'b0;
        m_tgt         = 0;
        m_base        = 0;
        m_data        = '0;
        @(negedge clk);

        // Full-rate streaming across all ports.
        do_reset(4'b0001);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, W'(8'h10 + i), 4'b1111, 4'b1111);
            chk("stream_ov", 32'(bus.out_valid), 32'(1 << (i % 4)));
            chk("stream_data", 32'(bus.out_data), 32'(8'h10 + i));
        end
        cyc(1'b0, 8'h00, 4'b1111, 4'b1111);

        // Only ports 1 and 3 eligible.
        do_reset(4'b0001);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, W'(8'h20 + i), 4'b1111, 4'b1010);
            chk("alt_ov", 32'(bus.out_valid), 32'((i % 2 == 0) ? 4'b0010 : 4'b1000));
        end
        cyc(1'b0, 8'h00, 4'b1111, 4'b1010);

        // Stall on port 2 for five cycles, then drain and load together.
        do_reset(4'b0100);
        cyc(1'b1, 8'h55, 4'b0000, 4'b1111);
        for (int i = 0; i < 5; i++) begin
            chk("hold_ov", 32'(bus.out_valid), 32'(4'b0100));
            chk("hold_data", 32'(bus.out_data), 32'h55);
            cyc(1'b1, 8'h66, 4'b1011, 4'b1111);
        end
        cyc(1'b1, 8'h66, 4'b0100, 4'b1111);
        chk("after_hold_ov", 32'(bus.out_valid), 32'(4'b1000));
        cyc(1'b0, 8'h00, 4'b1111, 4'b1111);

        // Disable the held port while it waits.
        do_reset(4'b0100);
        cyc(1'b1, 8'h71, 4'b0000, 4'b1111);
        cyc(1'b0, 8'h00, 4'b0000, 4'b1011);
        cyc(1'b1, 8'h72, 4'b0100, 4'b1011);
        chk("dis_next_ov", 32'(bus.out_valid), 32'(4'b1000));
        cyc(1'b0, 8'h00, 4'b1111, 4'b1011);

        // No eligible port: nothing accepted, held item still leaves.
        cyc(1'b1, 8'h81, 4'b0000, 4'b1111);
        cyc(1'b1, 8'h82, 4'b0000, 4'b0000);
        cyc(1'b1, 8'h83, 4'b1111, 4'b0000);
        chk("pe0_busy", 32'(bus.busy), 32'h0);
        cyc(1'b1, 8'h84, 4'b1111, 4'b0000);

        // Reset pulse while an item is held.
        do_reset(4'b0001);
        cyc(1'b1, 8'h91, 4'b0000, 4'b1111);
        bus.in_valid = 1'b0;
        base         = 4'b0100;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ov", 32'(bus.out_valid), 32'h0);
        chk("midrst_busy", 32'(bus.busy), 32'h0);
        m_full = 1'b0;
        m_base = 2;
        m_tgt  = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 8'h00, 4'b1111, 4'b1111);
        cyc(1'b1, 8'h92, 4'b1111, 4'b1111);
        chk("postrst_ov", 32'(bus.out_valid), 32'(4'b0100));

        // Random traffic, backpressure and eligibility changes.
        for (int i = 0; i < 400; i++) begin
            logic [N-1:0] pe;
            logic [N-1:0] ordy;
            pe   = ($urandom_range(0, 9) == 0) ? 4'b0000 : N'($urandom);
            ordy = ($urandom_range(0, 3) == 0) ? 4'b1111 : N'($urandom);
            cyc(1'($urandom_range(0, 3) != 0), W'($urandom), ordy, pe);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
